// File: rtl/axis_pkt_gen.sv
// AXI-stream packet generator: LFSR or counting payload, programmable packet
// length, packet count, inter-packet gap and round-robin channel ID, with full
// valid/ready backpressure.
module axis_pkt_gen #(
    parameter int unsigned   DATAW   = 64,
    parameter int unsigned   MAX_LEN = 256,
    parameter int unsigned   NUM_CH  = 4,
    parameter logic [63:0]   SEED    = 64'hFEDCBA9876543210,
    localparam int unsigned  LENW    = $clog2(MAX_LEN + 1),
    localparam int unsigned  IDW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_mode,
    input  logic [LENW-1:0]  cfg_len,
    input  logic [15:0]      cfg_npkt,
    input  logic [7:0]       cfg_gap,
    output logic [DATAW-1:0] m_data,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             m_last,
    output logic [IDW-1:0]   m_id,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [63:0]     src;
    logic            mode_r;
    logic [LENW-1:0] len_r;
    logic [LENW-1:0] beat_idx;
    logic [15:0]     npkt_r;
    logic [7:0]      gap_r;
    logic [7:0]      gap_cnt;
    logic            stop_pend;

    logic [LENW-1:0] len_eff_c;
    logic [63:0]     src_nxt_c;
    logic [IDW-1:0]  id_nxt_c;
    logic [15:0]     pkt_inc_c;
    logic [LENW-1:0] idx_inc_c;
    logic            next_last_c;
    logic            beat_acc_c;
    logic            run_end_c;
    logic            finish_c;

    // Clamp requested length into 1..MAX_LEN
    always_comb begin
        len_eff_c = cfg_len;
        if (cfg_len == '0) begin
            len_eff_c = LENW'(1);
        end else if (cfg_len > LENW'(MAX_LEN)) begin
            len_eff_c = LENW'(MAX_LEN);
        end
    end

    // Next payload word, next channel and per-beat bookkeeping
    always_comb begin
        src_nxt_c   = mode_r ? (src + 64'd1)
                             : {src[62:0], src[63] ^ src[62] ^ src[60] ^ src[59]};
        id_nxt_c    = (m_id == IDW'(NUM_CH - 1)) ? '0 : (m_id + IDW'(1));
        pkt_inc_c   = pkt_cnt + 16'd1;
        idx_inc_c   = beat_idx + LENW'(1);
        next_last_c = (idx_inc_c == (len_r - LENW'(1)));
        beat_acc_c  = m_vld & m_rdy;
        run_end_c   = ((npkt_r != 16'd0) && (pkt_inc_c == npkt_r)) || stop_pend || stop;
        finish_c    = ((state == ST_RUN) && beat_acc_c && m_last && run_end_c) ||
                      ((state == ST_GAP) && (stop_pend || stop));
    end

    // Run control, payload generation and registered stream outputs
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= ST_IDLE;
            src       <= SEED;
            mode_r    <= 1'b0;
            len_r     <= LENW'(1);
            beat_idx  <= '0;
            npkt_r    <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            m_data    <= '0;
            m_vld     <= 1'b0;
            m_last    <= 1'b0;
            m_id      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // stop in IDLE (including alongside start) is discarded
                    if (start) begin
                        mode_r    <= cfg_mode;
                        len_r     <= len_eff_c;
                        npkt_r    <= cfg_npkt;
                        gap_r     <= cfg_gap;
                        stop_pend <= 1'b0;
                        src       <= cfg_mode ? 64'd0 : SEED;
                        m_data    <= cfg_mode ? '0 : SEED[DATAW-1:0];
                        m_vld     <= 1'b1;
                        m_last    <= (len_eff_c == LENW'(1));
                        m_id      <= '0;
                        beat_idx  <= '0;
                        pkt_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (beat_acc_c) begin
                        src    <= src_nxt_c;
                        m_data <= src_nxt_c[DATAW-1:0];
                        if (!m_last) begin
                            beat_idx <= idx_inc_c;
                            m_last   <= next_last_c;
                        end else begin
                            pkt_cnt  <= pkt_inc_c;
                            beat_idx <= '0;
                            m_id     <= id_nxt_c;
                            if (gap_r == 8'd0) begin
                                m_last <= (len_r == LENW'(1));
                            end else begin
                                m_vld   <= 1'b0;
                                m_last  <= 1'b0;
                                gap_cnt <= gap_r - 8'd1;
                                state   <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        m_vld  <= 1'b1;
                        m_last <= (len_r == LENW'(1));
                        state  <= ST_RUN;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // End of run overrides the per-state updates above
            if (finish_c) begin
                state     <= ST_IDLE;
                done      <= 1'b1;
                busy      <= 1'b0;
                m_vld     <= 1'b0;
                m_last    <= 1'b0;
                m_id      <= '0;
                m_data    <= '0;
                beat_idx  <= '0;
                stop_pend <= 1'b0;
                src       <= mode_r ? 64'd0 : SEED;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen (MAX_LEN=16, NUM_CH=3, DATAW=64).
module tb_axis_pkt_gen;

    localparam logic [63:0] SEED = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        s_rst_n;
    logic        start;
    logic        stop;
    logic        cfg_mode;
    logic [4:0]  cfg_len;
    logic [15:0] cfg_npkt;
    logic [7:0]  cfg_gap;
    logic [63:0] m_data;
    logic        m_vld;
    logic        m_rdy;
    logic        m_last;
    logic [1:0]  m_id;
    logic        busy;
    logic        done;
    logic [15:0] pkt_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [63:0] q_data[$];
    logic        q_last[$];
    logic [1:0]  q_id[$];
    int          q_gap[$];
    int          done_cyc;
    int          last_acc_cyc;
    int          stab_err;
    int          bubbles;
    bit          done_seen;
    logic        busy_at_done;
    logic [15:0] pkt_at_done;

    axis_pkt_gen #(
        .DATAW   (64),
        .MAX_LEN (16),
        .NUM_CH  (3),
        .SEED    (SEED)
    ) dut (
        .clk      (clk),
        .s_rst_n  (s_rst_n),
        .start    (start),
        .stop     (stop),
        .cfg_mode (cfg_mode),
        .cfg_len  (cfg_len),
        .cfg_npkt (cfg_npkt),
        .cfg_gap  (cfg_gap),
        .m_data   (m_data),
        .m_vld    (m_vld),
        .m_rdy    (m_rdy),
        .m_last   (m_last),
        .m_id     (m_id),
        .busy     (busy),
        .done     (done),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Pulse start with a configuration on the next falling edge
    task automatic launch(input bit mode, input logic [4:0] len,
                          input logic [15:0] npkt, input logic [7:0] gap);
        @(negedge clk);
        cfg_mode = mode;
        cfg_len  = len;
        cfg_npkt = npkt;
        cfg_gap  = gap;
        start    = 1'b1;
    endtask

    // Step the stream, record accepted beats, gaps, bubbles and stall stability
    task automatic collect(input int max_cyc, input int rdy_pct,
                           input int stop_at, input int start_at);
        int          cyc = 0;
        int          gapc = 0;
        bit          in_gap = 0;
        bit          started = 0;
        bit          stall = 0;
        bit          stop_fired = 0;
        bit          start_fired = 0;
        logic [63:0] p_data = '0;
        logic        p_last = 1'b0;
        logic [1:0]  p_id = '0;
        q_data.delete(); q_last.delete(); q_id.delete(); q_gap.delete();
        done_seen = 0; done_cyc = -1; last_acc_cyc = -100;
        stab_err = 0; bubbles = 0; busy_at_done = 1'bx; pkt_at_done = 'x;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            stop  = 1'b0;
            m_rdy = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
            if (done) begin
                done_seen    = 1;
                done_cyc     = cyc;
                busy_at_done = busy;
                pkt_at_done  = pkt_cnt;
                break;
            end
            if (stall && (!m_vld || m_data !== p_data || m_last !== p_last || m_id !== p_id))
                stab_err++;
            if (in_gap) begin
                if (m_vld) begin
                    q_gap.push_back(gapc);
                    in_gap = 0;
                end else begin
                    gapc++;
                end
            end else if (started && !m_vld) begin
                bubbles++;
            end
            if (m_vld) started = 1;
            if (!stop_fired && stop_at >= 0 && m_vld && q_data.size() == stop_at) begin
                stop = 1'b1;
                stop_fired = 1;
            end
            if (!start_fired && start_at >= 0 && m_vld && q_data.size() == start_at) begin
                start = 1'b1;
                start_fired = 1;
            end
            stall  = m_vld && !m_rdy;
            p_data = m_data;
            p_last = m_last;
            p_id   = m_id;
            if (m_vld && m_rdy) begin
                q_data.push_back(m_data);
                q_last.push_back(m_last);
                q_id.push_back(m_id);
                if (m_last) begin
                    last_acc_cyc = cyc;
                    in_gap = 1;
                    gapc = 0;
                end
            end
        end
        m_rdy = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset;
        s_rst_n = 1'b0;
        #12;
        vec_cnt++;
        if ({m_vld, m_last, busy, done} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b expected 0000", {m_vld, m_last, busy, done});
        end
        vec_cnt++;
        if (m_data !== 64'd0 || m_id !== 2'd0 || pkt_cnt !== 16'd0) begin
            err_cnt++;
            $display("FAIL reset_values: got data=%h id=%0d pkt=%0d expected 0/0/0", m_data, m_id, pkt_cnt);
        end
        @(negedge clk);
        s_rst_n = 1'b1;
    endtask

    // Counting payload, two back-to-back packets of 4
    task automatic test_counting;
        launch(1'b1, 5'd4, 16'd2, 8'd0);
        collect(100, 100, -1, -1);
        vec_cnt++;
        if (q_data.size() != 8) begin
            err_cnt++;
            $display("FAIL t1_beats: got %0d expected 8", q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            logic [63:0] ed = 64'(i);
            logic        el = (i % 4 == 3);
            logic [1:0]  ei = 2'(i / 4);
            vec_cnt++;
            if (q_data[i] !== ed || q_last[i] !== el || q_id[i] !== ei) begin
                err_cnt++;
                $display("FAIL t1_beat[%0d]: got d=%h l=%b id=%0d expected d=%h l=%b id=%0d",
                         i, q_data[i], q_last[i], q_id[i], ed, el, ei);
            end
        end
        vec_cnt++;
        if (!done_seen || done_cyc != last_acc_cyc + 1) begin
            err_cnt++;
            $display("FAIL t1_done: got seen=%0d cyc=%0d expected seen=1 cyc=%0d", done_seen, done_cyc, last_acc_cyc + 1);
        end
        vec_cnt++;
        if (pkt_at_done !== 16'd2 || busy_at_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL t1_pktcnt: got pkt=%0d busy=%b expected pkt=2 busy=0", pkt_at_done, busy_at_done);
        end
        vec_cnt++;
        if (q_gap.size() != 1 || q_gap[0] != 0 || bubbles != 0) begin
            err_cnt++;
            $display("FAIL t1_b2b: got gaps=%0d bubbles=%0d expected gaps={0} bubbles=0", q_gap.size(), bubbles);
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b0) begin
            err_cnt++;
            $display("FAIL t1_done_pulse: got %b expected 0", done);
        end
    endtask

    // Same run under random backpressure
    task automatic test_backpressure;
        launch(1'b1, 5'd4, 16'd2, 8'd0);
        collect(300, 50, -1, -1);
        vec_cnt++;
        if (stab_err != 0) begin
            err_cnt++;
            $display("FAIL t2_stable: got %0d unstable stalls expected 0", stab_err);
        end
        vec_cnt++;
        if (q_data.size() != 8 || !done_seen) begin
            err_cnt++;
            $display("FAIL t2_beats: got %0d beats done=%0d expected 8 beats done=1", q_data.size(), done_seen);
        end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (q_data[i] !== 64'(i) || q_last[i] !== (i % 4 == 3) || q_id[i] !== 2'(i / 4)) begin
                err_cnt++;
                $display("FAIL t2_beat[%0d]: got d=%h l=%b id=%0d expected d=%0d l=%0d id=%0d",
                         i, q_data[i], q_last[i], q_id[i], i, (i % 4 == 3), i / 4);
            end
        end
    endtask

    // Inter-packet gap of 3 cycles, three packets
    task automatic test_gap;
        launch(1'b1, 5'd2, 16'd3, 8'd3);
        collect(100, 100, -1, -1);
        vec_cnt++;
        if (q_gap.size() != 2 || q_gap[0] != 3 || q_gap[1] != 3) begin
            err_cnt++;
            $display("FAIL t3_gap: got n=%0d g0=%0d g1=%0d expected n=2 g0=3 g1=3",
                     q_gap.size(), q_gap[0], q_gap[1]);
        end
        vec_cnt++;
        if (bubbles != 0 || q_data.size() != 6) begin
            err_cnt++;
            $display("FAIL t3_bubbles: got bubbles=%0d beats=%0d expected 0/6", bubbles, q_data.size());
        end
        for (int i = 0; i < 6; i++) begin
            vec_cnt++;
            if (q_id[i] !== 2'(i / 2) || q_data[i] !== 64'(i)) begin
                err_cnt++;
                $display("FAIL t3_beat[%0d]: got id=%0d d=%h expected id=%0d d=%0d", i, q_id[i], q_data[i], i / 2, i);
            end
        end
        vec_cnt++;
        if (!done_seen || pkt_at_done !== 16'd3) begin
            err_cnt++;
            $display("FAIL t3_done: got seen=%0d pkt=%0d expected 1/3", done_seen, pkt_at_done);
        end
    endtask

    // Unlimited run stopped mid-packet; start while busy ignored
    task automatic test_stop;
        launch(1'b1, 5'd8, 16'd0, 8'd0);
        collect(100, 100, 2, 5);
        vec_cnt++;
        if (q_data.size() != 8 || !done_seen) begin
            err_cnt++;
            $display("FAIL t4_beats: got %0d beats done=%0d expected 8 beats done=1", q_data.size(), done_seen);
        end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (q_data[i] !== 64'(i) || q_last[i] !== (i == 7)) begin
                err_cnt++;
                $display("FAIL t4_beat[%0d]: got d=%h l=%b expected d=%0d l=%0d", i, q_data[i], q_last[i], i, (i == 7));
            end
        end
        vec_cnt++;
        if (busy_at_done !== 1'b0 || pkt_at_done !== 16'd1 || done_cyc != last_acc_cyc + 1) begin
            err_cnt++;
            $display("FAIL t4_end: got busy=%b pkt=%0d dcyc=%0d expected busy=0 pkt=1 dcyc=%0d",
                     busy_at_done, pkt_at_done, done_cyc, last_acc_cyc + 1);
        end
    endtask

    // LFSR payload, asynchronous reset mid-packet, restart from SEED
    task automatic test_lfsr_reset;
        logic [63:0] exp_lfsr[3];
        exp_lfsr[0] = 64'hFEDCBA9876543210;
        exp_lfsr[1] = 64'hFDB97530ECA86420;
        exp_lfsr[2] = 64'hFB72EA61D950C840;
        launch(1'b0, 5'd4, 16'd1, 8'd0);
        collect(100, 100, -1, -1);
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (q_data[i] !== exp_lfsr[i]) begin
                err_cnt++;
                $display("FAIL t5_lfsr[%0d]: got %h expected %h", i, q_data[i], exp_lfsr[i]);
            end
        end
        launch(1'b0, 5'd8, 16'd0, 8'd0);
        collect(3, 100, -1, -1);
        #1;
        s_rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (m_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL t5_async_rst: got vld=%b busy=%b done=%b expected 0/0/0", m_vld, busy, done);
        end
        @(negedge clk);
        s_rst_n = 1'b1;
        launch(1'b0, 5'd4, 16'd1, 8'd0);
        collect(100, 100, -1, -1);
        vec_cnt++;
        if (q_data[0] !== SEED || !done_seen) begin
            err_cnt++;
            $display("FAIL t5_restart: got %h done=%0d expected %h done=1", q_data[0], done_seen, SEED);
        end
    endtask

    // Length clamps, channel wrap with NUM_CH=3, start beats stop in IDLE
    task automatic test_bounds;
        launch(1'b1, 5'd0, 16'd2, 8'd0);
        stop = 1'b1;
        collect(100, 100, -1, -1);
        vec_cnt++;
        if (q_data.size() != 2 || q_last[0] !== 1'b1 || q_last[1] !== 1'b1) begin
            err_cnt++;
            $display("FAIL t6_len0: got beats=%0d l0=%b l1=%b expected 2/1/1", q_data.size(), q_last[0], q_last[1]);
        end
        launch(1'b1, 5'd21, 16'd1, 8'd0);
        collect(100, 100, -1, -1);
        vec_cnt++;
        if (q_data.size() != 16 || q_last[15] !== 1'b1 || q_last[14] !== 1'b0 || q_data[15] !== 64'd15) begin
            err_cnt++;
            $display("FAIL t6_lenmax: got beats=%0d l15=%b l14=%b d15=%h expected 16/1/0/f",
                     q_data.size(), q_last[15], q_last[14], q_data[15]);
        end
        launch(1'b1, 5'd1, 16'd4, 8'd0);
        collect(100, 100, -1, -1);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ei = 2'(i % 3);
            vec_cnt++;
            if (q_id[i] !== ei || q_last[i] !== 1'b1) begin
                err_cnt++;
                $display("FAIL t6_id[%0d]: got id=%0d l=%b expected id=%0d l=1", i, q_id[i], q_last[i], ei);
            end
        end
        vec_cnt++;
        if (!done_seen || pkt_at_done !== 16'd4) begin
            err_cnt++;
            $display("FAIL t6_done: got seen=%0d pkt=%0d expected 1/4", done_seen, pkt_at_done);
        end
    endtask

    initial begin
        start    = 1'b0;
        stop     = 1'b0;
        cfg_mode = 1'b0;
        cfg_len  = '0;
        cfg_npkt = '0;
        cfg_gap  = '0;
        m_rdy    = 1'b1;
        test_reset();
        test_counting();
        test_backpressure();
        test_gap();
        test_stop();
        test_lfsr_reset();
        test_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
